// File: rtl/vx_tcu_uop_sequencer.sv
// ---------------------------------------------------------------------------
// vx_tcu_uop_sequencer
//
// Expands one accepted WMMA instruction into M_STEPS*N_STEPS*K_STEPS
// micro-ops. The K step is innermost, then N, then M outermost. Each uop
// carries the captured instruction tag and formats, the step indices, and
// the A/B/C register indices derived from those steps.
//
// Ports
//   clk, reset_n           : clock, synchronous active-low reset
//   in_valid / in_ready    : instruction handshake (ready only while idle)
//   in_tag, in_fmt_s/_d    : instruction tag, source/destination format IDs
//   out_valid / out_ready  : micro-op handshake
//   out_tag, out_fmt_s/_d  : values captured from the accepted instruction
//   out_step_m/_n/_k       : current step indices
//   out_ra, out_rb, out_rc : A, B, C register indices
//   out_first, out_last    : first / last uop of the instruction
//   busy                   : sequencer is issuing uops
//   fmt_err                : one-cycle pulse after an invalid format pair
// ---------------------------------------------------------------------------
module vx_tcu_uop_sequencer #(
  parameter int M_STEPS = 2,
  parameter int N_STEPS = 4,
  parameter int K_STEPS = 4,
  parameter int RA_BASE = 0,
  parameter int RB_BASE = 10,
  parameter int RC_BASE = 24,
  parameter int TAG_W   = 8,
  localparam int SM_W   = (M_STEPS > 1) ? $clog2(M_STEPS) : 1,
  localparam int SN_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1,
  localparam int SK_W   = (K_STEPS > 1) ? $clog2(K_STEPS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [3:0]       in_fmt_s,
  input  logic [3:0]       in_fmt_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_fmt_s,
  output logic [3:0]       out_fmt_d,
  output logic [SM_W-1:0]  out_step_m,
  output logic [SN_W-1:0]  out_step_n,
  output logic [SK_W-1:0]  out_step_k,
  output logic [4:0]       out_ra,
  output logic [4:0]       out_rb,
  output logic [4:0]       out_rc,
  output logic             out_first,
  output logic             out_last,
  output logic             busy,
  output logic             fmt_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [SM_W-1:0] step_m, step_m_n;
  logic [SN_W-1:0] step_n, step_n_n;
  logic [SK_W-1:0] step_k, step_k_n;
  logic            fmt_err_n;
  logic            cap_en;

  logic [TAG_W-1:0] tag_q;
  logic [3:0]       fmt_s_q;
  logic [3:0]       fmt_d_q;

  logic m_end, n_end, k_end;

  function automatic logic fmt_s_ok(input logic [3:0] f);
    case (f)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd9, 4'd10, 4'd11, 4'd12: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic fmt_d_ok(input logic [3:0] f);
    return (f == 4'd0) || (f == 4'd8);
  endfunction

  assign m_end = (step_m == SM_W'(M_STEPS - 1));
  assign n_end = (step_n == SN_W'(N_STEPS - 1));
  assign k_end = (step_k == SK_W'(K_STEPS - 1));

  // Next-state and step advance
  always_comb begin
    state_n   = state;
    step_m_n  = step_m;
    step_n_n  = step_n;
    step_k_n  = step_k;
    fmt_err_n = 1'b0;
    cap_en    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          cap_en   = 1'b1;
          step_m_n = '0;
          step_n_n = '0;
          step_k_n = '0;
          // A bad format pair is still consumed so the issuer does not
          // stall; it only produces the error pulse.
          if (fmt_s_ok(in_fmt_s) && fmt_d_ok(in_fmt_d)) begin
            state_n = ISSUE;
          end else begin
            fmt_err_n = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (out_ready) begin
          if (m_end && n_end && k_end) begin
            state_n = IDLE;
          end else if (!k_end) begin
            step_k_n = step_k + SK_W'(1);
          end else if (!n_end) begin
            step_k_n = '0;
            step_n_n = step_n + SN_W'(1);
          end else begin
            step_k_n = '0;
            step_n_n = '0;
            step_m_n = step_m + SM_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      step_m  <= '0;
      step_n  <= '0;
      step_k  <= '0;
      fmt_err <= 1'b0;
    end else begin
      state   <= state_n;
      step_m  <= step_m_n;
      step_n  <= step_n_n;
      step_k  <= step_k_n;
      fmt_err <= fmt_err_n;
    end
  end

  // Captured instruction fields (payload only, no reset needed)
  always_ff @(posedge clk) begin
    if (cap_en) begin
      tag_q   <= in_tag;
      fmt_s_q <= in_fmt_s;
      fmt_d_q <= in_fmt_d;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == ISSUE);
  assign busy      = (state != IDLE);

  assign out_tag    = tag_q;
  assign out_fmt_s  = fmt_s_q;
  assign out_fmt_d  = fmt_d_q;
  assign out_step_m = step_m;
  assign out_step_n = step_n;
  assign out_step_k = step_k;

  // Register indices wrap modulo 32 through the 5-bit truncation.
  assign out_ra = 5'(RA_BASE + int'(step_m) * K_STEPS + int'(step_k));
  assign out_rb = 5'(RB_BASE + int'(step_n) * K_STEPS + int'(step_k));
  assign out_rc = 5'(RC_BASE + int'(step_m) * N_STEPS + int'(step_n));

  assign out_first = (step_m == '0) && (step_n == '0) && (step_k == '0);
  assign out_last  = m_end && n_end && k_end;

endmodule

// File: tb/tb_vx_tcu_uop_sequencer.sv
module tb_vx_tcu_uop_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_tag, out_tag;
  logic [3:0] in_fmt_s, in_fmt_d, out_fmt_s, out_fmt_d;
  logic [0:0] out_step_m;
  logic [1:0] out_step_n, out_step_k;
  logic [4:0] out_ra, out_rb, out_rc;
  logic       out_first, out_last, busy, fmt_err;

  vx_tcu_uop_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_fmt_s(out_fmt_s), .out_fmt_d(out_fmt_d),
    .out_step_m(out_step_m), .out_step_n(out_step_n), .out_step_k(out_step_k),
    .out_ra(out_ra), .out_rb(out_rb), .out_rc(out_rc),
    .out_first(out_first), .out_last(out_last),
    .busy(busy), .fmt_err(fmt_err)
  );

  // Single-step instance (M=N=K=1)
  logic       u_in_valid, u_in_ready, u_out_valid, u_out_ready;
  logic [7:0] u_in_tag, u_out_tag;
  logic [3:0] u_in_fmt_s, u_in_fmt_d, u_out_fmt_s, u_out_fmt_d;
  logic [0:0] u_step_m, u_step_n, u_step_k;
  logic [4:0] u_ra, u_rb, u_rc;
  logic       u_first, u_last, u_busy, u_fmt_err;

  vx_tcu_uop_sequencer #(.M_STEPS(1), .N_STEPS(1), .K_STEPS(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(u_in_valid), .in_ready(u_in_ready),
    .in_tag(u_in_tag), .in_fmt_s(u_in_fmt_s), .in_fmt_d(u_in_fmt_d),
    .out_valid(u_out_valid), .out_ready(u_out_ready),
    .out_tag(u_out_tag), .out_fmt_s(u_out_fmt_s), .out_fmt_d(u_out_fmt_d),
    .out_step_m(u_step_m), .out_step_n(u_step_n), .out_step_k(u_step_k),
    .out_ra(u_ra), .out_rb(u_rb), .out_rc(u_rc),
    .out_first(u_first), .out_last(u_last),
    .busy(u_busy), .fmt_err(u_fmt_err)
  );

  int tests = 0;
  int failed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected uop fields for index idx of the default 2x4x4 instruction.
  task automatic chk_uop(input string nm, input int idx);
    int m, n, k;
    m = idx / 16;
    n = (idx / 4) % 4;
    k = idx % 4;
    chk($sformatf("%s_valid", nm), 32'(out_valid), 32'd1);
    chk($sformatf("%s_m", nm), 32'(out_step_m), 32'(m));
    chk($sformatf("%s_n", nm), 32'(out_step_n), 32'(n));
    chk($sformatf("%s_k", nm), 32'(out_step_k), 32'(k));
    chk($sformatf("%s_ra", nm), 32'(out_ra), 32'(m * 4 + k));
    chk($sformatf("%s_rb", nm), 32'(out_rb), 32'(10 + n * 4 + k));
    chk($sformatf("%s_rc", nm), 32'(out_rc), 32'(24 + m * 4 + n));
    chk($sformatf("%s_first", nm), 32'(out_first), 32'(idx == 0));
    chk($sformatf("%s_last", nm), 32'(out_last), 32'(idx == 31));
  endtask

  task automatic send(input logic [7:0] tag, input logic [3:0] fs, input logic [3:0] fd);
    in_tag   = tag;
    in_fmt_s = fs;
    in_fmt_d = fd;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0] fs;
    logic [3:0] fd;
    logic [7:0] tag;
    logic       err;
  } fmt_vec_t;

  fmt_vec_t vecs[8];

  logic [63:0] snap, cur;
  logic        stall_prev;
  int          idx, cyc, cnt;
  logic        rdy;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'd1,  4'd0, 8'h11, 1'b0};
    vecs[1] = '{4'd5,  4'd0, 8'h22, 1'b1};
    vecs[2] = '{4'd0,  4'd8, 8'h33, 1'b0};
    vecs[3] = '{4'd12, 4'd8, 8'h44, 1'b0};
    vecs[4] = '{4'd9,  4'd3, 8'h55, 1'b1};
    vecs[5] = '{4'd4,  4'd0, 8'h66, 1'b1};
    vecs[6] = '{4'd15, 4'd8, 8'h77, 1'b1};
    vecs[7] = '{4'd3,  4'd0, 8'h88, 1'b0};

    reset_n = 1'b0;
    in_valid = 1'b0; in_tag = '0; in_fmt_s = '0; in_fmt_d = '0; out_ready = 1'b0;
    u_in_valid = 1'b0; u_in_tag = '0; u_in_fmt_s = '0; u_in_fmt_d = '0; u_out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fmt_err", 32'(fmt_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Full 32-uop sequence, no backpressure
    out_ready = 1'b1;
    send(8'h5A, 4'd1, 4'd0);
    chk("seq_uop0_ra", 32'(out_ra), 32'd0);
    chk("seq_uop0_rb", 32'(out_rb), 32'd10);
    chk("seq_uop0_rc", 32'(out_rc), 32'd24);
    chk("seq_uop0_first", 32'(out_first), 32'd1);
    chk("seq_tag", 32'(out_tag), 32'h5A);
    chk("seq_fmt_s", 32'(out_fmt_s), 32'd1);
    chk("seq_in_ready", 32'(in_ready), 32'd0);
    for (int m = 0; m < 2; m++)
      for (int n = 0; n < 4; n++)
        for (int k = 0; k < 4; k++) begin
          chk_uop($sformatf("seq%0d", m * 16 + n * 4 + k), m * 16 + n * 4 + k);
          if (m == 1 && n == 3 && k == 3) begin
            chk("seq_uop31_ra", 32'(out_ra), 32'd7);
            chk("seq_uop31_rb", 32'(out_rb), 32'd25);
            chk("seq_uop31_rc", 32'(out_rc), 32'd31);
            chk("seq_uop31_last", 32'(out_last), 32'd1);
          end
          tick();
        end
    chk("seq_end_valid", 32'(out_valid), 32'd0);
    chk("seq_end_in_ready", 32'(in_ready), 32'd1);
    chk("seq_end_busy", 32'(busy), 32'd0);

    // Random backpressure
    out_ready = 1'b0;
    send(8'hC3, 4'd10, 4'd8);
    idx = 0; cyc = 0; stall_prev = 1'b0; snap = '0;
    while (idx < 32 && cyc < 400) begin
      chk_uop($sformatf("bp%0d", idx), idx);
      cur = {out_tag, out_fmt_s, out_fmt_d, out_ra, out_rb, out_rc,
             out_step_m, out_step_n, out_step_k, out_first, out_last, 21'd0};
      if (stall_prev) chk("bp_stable", cur[63:21], snap[63:21]);
      snap = cur;
      rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      tick();
      if (rdy) idx++;
      stall_prev = !rdy;
      cyc++;
    end
    chk("bp_count", 32'(idx), 32'd32);
    chk("bp_end_valid", 32'(out_valid), 32'd0);
    chk("bp_end_in_ready", 32'(in_ready), 32'd1);

    // Format validity table
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].tag, vecs[i].fs, vecs[i].fd);
      chk($sformatf("fmt%0d_err", i), 32'(fmt_err), 32'(vecs[i].err));
      chk($sformatf("fmt%0d_valid", i), 32'(out_valid), 32'(!vecs[i].err));
      chk($sformatf("fmt%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].err));
      chk($sformatf("fmt%0d_tag", i), 32'(out_tag), 32'(vecs[i].tag));
      tick();
      chk($sformatf("fmt%0d_err_clr", i), 32'(fmt_err), 32'd0);
      if (vecs[i].err) chk($sformatf("fmt%0d_no_uop", i), 32'(out_valid), 32'd0);
      cnt = 0;
      while (out_valid && cnt < 64) begin
        tick();
        cnt++;
      end
      chk($sformatf("fmt%0d_idle", i), 32'(busy), 32'd0);
    end

    // Reset in the middle of a sequence
    send(8'h3C, 4'd2, 4'd0);
    for (int i = 0; i < 10; i++) tick();
    chk_uop("mid10", 10);
    reset_n = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_no_resume", 32'(out_valid), 32'd0);
    send(8'h99, 4'd0, 4'd0);
    chk_uop("restart0", 0);
    chk("restart_tag", 32'(out_tag), 32'h99);
    out_ready = 1'b1;
    cnt = 0;
    while (out_valid && cnt < 64) begin
      tick();
      cnt++;
    end
    chk("restart_count", 32'(cnt), 32'd32);

    // Single-step instance, in_valid held high
    u_in_tag = 8'hE1; u_in_fmt_s = 4'd11; u_in_fmt_d = 4'd8;
    u_out_ready = 1'b1;
    u_in_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("one%0d_valid", i), 32'(u_out_valid), 32'((i % 2) == 0));
      chk($sformatf("one%0d_in_ready", i), 32'(u_in_ready), 32'((i % 2) == 1));
      if ((i % 2) == 0) begin
        chk($sformatf("one%0d_first", i), 32'(u_first), 32'd1);
        chk($sformatf("one%0d_last", i), 32'(u_last), 32'd1);
        chk($sformatf("one%0d_regs", i), {17'd0, u_ra, u_rb, u_rc}, {17'd0, 5'd0, 5'd10, 5'd24});
        chk($sformatf("one%0d_tag", i), 32'(u_out_tag), 32'hE1);
      end
      if (u_out_valid) cnt++;
    end
    u_in_valid = 1'b0;
    chk("one_uop_count", 32'(cnt), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
